// File: rtl/demux2_stream_if.sv
// Stream bundle for demux2_stream: one producer port plus two independent consumer ports.
// The slave modport is the demux side; master is the producer/consumer environment.
interface demux2_stream_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 2
);
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sel_err;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic [CW-1:0]    a_count;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic [CW-1:0]    b_count;

  modport slave (
    input  in_valid, in_sel, in_data, a_ready, b_ready,
    output in_ready, sel_err, a_valid, a_data, a_count, b_valid, b_data, b_count
  );

  modport master (
    output in_valid, in_sel, in_data, a_ready, b_ready,
    input  in_ready, sel_err, a_valid, a_data, a_count, b_valid, b_data, b_count
  );
endinterface

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer with a private DEPTH-entry FIFO per output,
// so a stalled consumer never blocks words bound for the other side.
module demux2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic            clock,
  input  logic            reset,
  demux2_stream_if.slave  s
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_q [2];
  logic [PW-1:0]    wr_ptr_d [2];
  logic [PW-1:0]    rd_ptr_q [2];
  logic [PW-1:0]    rd_ptr_d [2];
  logic [CW-1:0]    count_q  [2];
  logic [CW-1:0]    count_d  [2];
  logic             sel_err_q;
  logic             sel_err_d;
  logic             sel_a_s;
  logic             sel_b_s;
  logic [1:0]       full_s;
  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic [1:0]       ready_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Select decode, handshake qualification and next-state for both FIFOs
  always_comb begin
    // Case-equality keeps an X/Z select from ever matching either destination
    sel_a_s   = (s.in_sel === 1'b0);
    sel_b_s   = (s.in_sel === 1'b1);
    ready_s   = {s.b_ready, s.a_ready};
    full_s    = 2'b00;
    pop_s     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      full_s[i] = (count_q[i] == CW'(DEPTH));
      pop_s[i]  = (count_q[i] != '0) && ready_s[i];
    end
    // A pop on a full FIFO does not free space for a push in the same cycle
    push_s[0]  = s.in_valid && sel_a_s && !full_s[0];
    push_s[1]  = s.in_valid && sel_b_s && !full_s[1];
    s.in_ready = !reset && ((sel_a_s && !full_s[0]) || (sel_b_s && !full_s[1]));
    sel_err_d  = s.in_valid && !sel_a_s && !sel_b_s;
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = push_s[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_s[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
      count_d[i]  = count_q[i] + CW'(push_s[i]) - CW'(pop_s[i]);
    end
  end

  // Pointer, occupancy and error-pulse state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      sel_err_q <= sel_err_d;
    end
  end

  // Storage is unreset: contents are only observed while the matching count is non-zero
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        mem_q[i][wr_ptr_q[i]] <= s.in_data;
      end
    end
  end

  assign s.sel_err = sel_err_q;
  assign s.a_valid = (count_q[0] != '0);
  assign s.a_data  = mem_q[0][rd_ptr_q[0]];
  assign s.a_count = count_q[0];
  assign s.b_valid = (count_q[1] != '0);
  assign s.b_data  = mem_q[1][rd_ptr_q[1]];
  assign s.b_count = count_q[1];
endmodule

// File: tb/tb_demux2_stream.sv
// Directed bench for demux2_stream: routing, full/backpressure, wrap/order, async reset, X select.
module tb_demux2_stream;
  logic clock;
  logic reset;
  int   tests;
  int   fails;

  demux2_stream_if #(.WIDTH(8), .CW(2)) bus ();

  demux2_stream #(.WIDTH(8), .DEPTH(2), .CW(2)) dut (
    .clock (clock),
    .reset (reset),
    .s     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin : main
    logic [7:0] nxt;
    logic [7:0] exp_out;
    int         mdl_cnt;
    int         cyc;
    logic       acc;
    logic       pop;
    logic [1:0] cnt_a_before;
    logic [1:0] cnt_b_before;
    logic       probe;

    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.in_data  = 8'h00;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
    chk("rst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("rst_a_count", 32'(bus.a_count), 32'd0);
    chk("rst_b_count", 32'(bus.b_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Routing: 11 to A, then 22 to B, both consumers ready
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 8'h11;
    #1 chk("route_in_ready_a", 32'(bus.in_ready), 32'd1);
    tick();
    chk("route_a_valid", 32'(bus.a_valid), 32'd1);
    chk("route_a_data", 32'(bus.a_data), 32'h11);
    chk("route_b_valid_idle", 32'(bus.b_valid), 32'd0);
    bus.in_sel  = 1'b1;
    bus.in_data = 8'h22;
    #1 chk("route_in_ready_b", 32'(bus.in_ready), 32'd1);
    tick();
    chk("route_a_drained", 32'(bus.a_valid), 32'd0);
    chk("route_b_valid", 32'(bus.b_valid), 32'd1);
    chk("route_b_data", 32'(bus.b_data), 32'h22);
    chk("route_sel_err", 32'(bus.sel_err), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("route_b_drained", 32'(bus.b_valid), 32'd0);

    // Fill A while B stays open
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 8'hA0;
    tick();
    chk("full_a_count1", 32'(bus.a_count), 32'd1);
    bus.in_data = 8'hA1;
    tick();
    chk("full_a_count2", 32'(bus.a_count), 32'd2);
    chk("full_a_head", 32'(bus.a_data), 32'hA0);
    chk("full_in_ready_sel0", 32'(bus.in_ready), 32'd0);
    bus.in_sel  = 1'b1;
    bus.in_data = 8'hB0;
    #1 chk("full_in_ready_sel1", 32'(bus.in_ready), 32'd1);
    tick();
    chk("full_b_count", 32'(bus.b_count), 32'd1);
    chk("full_b_data", 32'(bus.b_data), 32'hB0);
    chk("full_a_hold", 32'(bus.a_count), 32'd2);

    // Push refused at full even with a simultaneous pop
    bus.in_sel  = 1'b0;
    bus.in_data = 8'hA2;
    bus.a_ready = 1'b1;
    #1 chk("pp_in_ready_full", 32'(bus.in_ready), 32'd0);
    tick();
    chk("pp_a_count_dec", 32'(bus.a_count), 32'd1);
    chk("pp_a_head", 32'(bus.a_data), 32'hA1);
    chk("pp_in_ready_after", 32'(bus.in_ready), 32'd1);
    tick();
    chk("pp_a_count_same", 32'(bus.a_count), 32'd1);
    chk("pp_a_head2", 32'(bus.a_data), 32'hA2);
    bus.in_valid = 1'b0;
    bus.b_ready  = 1'b1;
    tick();
    chk("pp_a_empty", 32'(bus.a_count), 32'd0);
    chk("pp_b_empty", 32'(bus.b_count), 32'd0);

    // Stream 00..09 into A with a toggling consumer
    nxt     = 8'h00;
    exp_out = 8'h00;
    mdl_cnt = 0;
    cyc     = 0;
    bus.b_ready = 1'b0;
    bus.in_sel  = 1'b0;
    while (exp_out < 8'd10 && cyc < 200) begin
      bus.in_valid = (nxt < 8'd10);
      bus.in_data  = nxt;
      bus.a_ready  = ~cyc[0];
      #1;
      acc = bus.in_valid && bus.in_ready;
      pop = bus.a_valid && bus.a_ready;
      if (pop) begin
        chk("wrap_order", 32'(bus.a_data), 32'(exp_out));
        exp_out = exp_out + 8'd1;
      end
      tick();
      if (acc) nxt = nxt + 8'd1;
      mdl_cnt = mdl_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
      chk("wrap_count", 32'(bus.a_count), 32'(mdl_cnt));
      chk("wrap_count_le2", 32'(bus.a_count <= 2'd2), 32'd1);
      cyc++;
    end
    chk("wrap_done_in_budget", 32'(exp_out), 32'd10);
    chk("wrap_all_sent", 32'(nxt), 32'd10);
    bus.in_valid = 1'b0;

    // Async reset mid-cycle with both FIFOs occupied
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 8'hC0;
    tick();
    bus.in_sel  = 1'b1;
    bus.in_data = 8'hC1;
    tick();
    bus.in_valid = 1'b0;
    chk("arst_pre_a", 32'(bus.a_count), 32'd1);
    chk("arst_pre_b", 32'(bus.b_count), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_a_valid", 32'(bus.a_valid), 32'd0);
    chk("arst_b_valid", 32'(bus.b_valid), 32'd0);
    chk("arst_a_count", 32'(bus.a_count), 32'd0);
    chk("arst_b_count", 32'(bus.b_count), 32'd0);
    tick();
    reset = 1'b0;

    // X select only has meaning on a four-state simulator
    probe = 1'bx;
    if ($isunknown(probe)) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'bx;
      bus.in_data  = 8'h5A;
      #1;
      cnt_a_before = bus.a_count;
      cnt_b_before = bus.b_count;
      chk("xsel_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      bus.in_sel   = 1'b0;
      chk("xsel_sel_err", 32'(bus.sel_err), 32'd1);
      chk("xsel_a_count", 32'(bus.a_count), 32'(cnt_a_before));
      chk("xsel_b_count", 32'(bus.b_count), 32'(cnt_b_before));
      tick();
      chk("xsel_err_clear", 32'(bus.sel_err), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
